// File: rtl/mux_stream_rr_pkg.sv
// Shared constants for the mux_stream_rr streaming multiplexer.
// The optional beat counter is enabled with MUX_STREAM_RR_CNT_EN.
package mux_stream_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int DEF_NCH = 16;
  localparam int DEF_W   = 8;

  localparam int               CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

endpackage

// File: rtl/mux_stream_rr_pick.sv
// Combinational rotate-priority picker: searches ptr+1, ptr+2, ... modulo NCH
// and reports the first requesting channel.
module rr_pick #(
  parameter int NCH  = 16,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);

  // The wrap is explicit so that a non-power-of-two NCH goes from NCH-1 back to 0.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_stream_rr.sv
// N:1 streaming mux with per-channel valid/ready, a registered output stage and
// fixed/round-robin mode. Define MUX_STREAM_RR_CNT_EN to add the beat_cnt port.
module mux_stream_rr
  import mux_stream_pkg::*;
#(
  parameter  int NCH  = DEF_NCH,
  parameter  int W    = DEF_W,
  localparam int SELW = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [NCH-1:0]  in_valid,
  input  logic [NCH*W-1:0] in_data,
  output logic [NCH-1:0]  in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_ch,
  input  logic            out_ready
`ifdef MUX_STREAM_RR_CNT_EN
  ,
  output logic [CNT_W-1:0] beat_cnt
`endif
);

  logic [SELW-1:0] ptr;
  logic            rr_valid;
  logic [SELW-1:0] rr_idx;
  logic            grant_valid;
  logic [SELW-1:0] grant_idx;
  logic            load_en;
  logic            take;

  rr_pick #(.NCH(NCH), .SELW(SELW)) u_pick (
    .req       (in_valid),
    .ptr       (ptr),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  // A new beat may enter when the register is empty or is being drained this cycle.
  assign load_en = !out_valid || out_ready;
  assign take    = rst_n && load_en && grant_valid;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (mode == MODE_RR) begin
      grant_valid = rr_valid;
      grant_idx   = rr_idx;
    end else if (int'(sel) < NCH && in_valid[sel]) begin
      grant_valid = 1'b1;
      grant_idx   = sel;
    end
  end

  always_comb begin
    in_ready = '0;
    if (take) in_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= SELW'(NCH - 1);
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant_idx*W +: W];
      out_ch    <= grant_idx;
      if (mode == MODE_RR) ptr <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_STREAM_RR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (out_valid && out_ready && beat_cnt != CNT_SAT) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/mux_stream_rr.md
Name: mux_stream_rr

Overview:
- Parametrised N:1 streaming multiplexer. It is the next generation of the team's combinational 16:1 mux, and adds per-channel valid/ready handshakes, a registered output stage, and a runtime mode.
- Mode selects between fixed channel select (the legacy `s`-driven behaviour) and round-robin arbitration.
- Sits between parallel producer lanes and a single downstream consumer.

Parameters:
- NCH, 16, number of input channels (2..64, power of two not required).
- W, 8, data width per channel in bits.
- SELW, $clog2(NCH), width of select and channel-ID fields (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel index used in fixed mode.
- in_valid  input  NCH  per-channel data valid.
- in_data  input  NCH*W  packed channel data; channel i occupies bits [i*W +: W].
- in_ready  output  NCH  per-channel accept (combinational).
- out_valid  output  1  registered output holds a beat.
- out_data  output  W  registered output data.
- out_ch  output  SELW  channel index of the beat in out_data.
- out_ready  input  1  consumer accepts.

Behaviour:
- Reset: single synchronous clock domain; reset is sampled on the clk edge while rst_n=0. Values during reset:
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer ptr=NCH-1, so channel 0 is checked first after reset.
  - in_ready all 0.
- load_en = !out_valid || out_ready. The output register accepts a new beat only when it is empty or draining in the same cycle, giving full throughput with no bubble.
- Grant, fixed mode (mode=0):
  - grant = sel when sel<NCH and in_valid[sel]=1; otherwise no grant.
  - sel>=NCH is never granted.
- Grant, round-robin mode (mode=1):
  - Search channels ptr+1, ptr+2, ... wrapping modulo NCH (non-power-of-two NCH wraps at NCH-1 to 0).
  - The first channel with in_valid=1 wins.
  - ptr is unchanged when no channel is valid.
- in_ready[i] = load_en && grant_valid && (grant==i). At most one bit is high, and it is combinational from in_valid, sel, mode, out_valid and out_ready.
- Transfer on input i when in_valid[i] && in_ready[i]. At the next edge:
  - out_data = channel i data.
  - out_ch = i.
  - out_valid = 1.
  - Round-robin mode only: ptr = i.
- Output drain: out_valid && out_ready with no new transfer gives out_valid=0; out_data and out_ch hold their last values.
- Backpressure: when out_valid=1 and out_ready=0, out_data and out_ch are stable and all in_ready=0.
- Latency: 1 cycle from input handshake to out_valid.
- Mode/sel changes take effect on the next grant evaluation (same cycle, combinational). A beat already registered is unaffected. ptr is kept across mode switches.
- Simultaneous drain and load: the new beat replaces the old beat in the same edge and out_valid stays 1.
- Reset mid-operation: any registered beat is discarded and no in_ready is asserted while rst_n=0.
- Producers must hold in_data stable while in_valid=1 and the channel is not yet accepted. The block does not check this.

Optional Feature:
- Macro: MUX_STREAM_RR_CNT_EN.
- When defined: adds output port beat_cnt [15:0].
  - Counts output transfers (out_valid && out_ready).
  - Saturates at 16'hFFFF.
  - Reset value 0.
- When undefined: port and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package mux_stream_pkg holds:
  - Mode constants MODE_FIXED=1'b0 and MODE_RR=1'b1.
  - Default NCH=16 and W=8.
  - Counter width CNT_W=16 and saturation value.
- One sub-module, rr_pick: purely combinational rotate-priority picker.
  - Inputs: req[NCH], ptr[SELW].
  - Outputs: gnt_valid, gnt_idx[SELW].
- Top level holds the mode mux, the output register and ptr.

Test Plan:
- Fixed mode sweep: mode=0, out_ready=1, for s=0..15 drive in_valid=1<<s and in_data lane s = 16'h0001<<s truncated to W (lane 0 = 8'h01, lane 3 = 8'h08, lanes 8..15 = 8'h00, with out_ch as the discriminator). Expect in_ready[s]=1, and next cycle out_data = lane s value and out_ch=s.
- Fixed mode ignores others: mode=0, sel=5, in_valid=16'hFFDF (channel 5 idle). Expect in_ready=0 and out_valid stays 0. Then raise in_valid[5] and expect a grant to 5 only.
- Round-robin fairness: mode=1, in_valid=16'hFFFF constant, out_ready=1. Expect out_ch sequence 0,1,2,...,15,0 on consecutive cycles with out_valid=1 every cycle.
- Round-robin skip and wrap: mode=1, in_valid=16'h8005. Expect out_ch sequence 0,2,15,0,2,15.
- Backpressure: fill the output with ch3 data 8'hA5, then hold out_ready=0 for 4 cycles. Expect out_data=8'hA5 and out_ch=3 stable, and in_ready=0. Release out_ready and expect the next beat in the same cycle.
- Reset mid-stream: while out_valid=1, assert rst_n=0 for 1 cycle. Expect out_valid=0, out_data=0 and out_ch=0 next cycle. In round-robin mode the first grant after reset goes to the lowest valid channel. With MUX_STREAM_RR_CNT_EN defined, beat_cnt returns to 0.
